cdc_tx_scheduler: RTL and testbench

Clock-domain-A front end for the 4-bit enable-qualified CDC channel (data + level enable, 2-flop enable synchronizer in clk_b). Arbitrates N requesters round-robin onto the single channel. For each transfer it drives data, holds the enable for a programmed number of cycles, and keeps data stable through a hold window. It optionally waits for a toggle acknowledge returned from the clk_b side before releasing the channel.

---
 rtl/cdc_tx_scheduler_if.sv | 27 ++
 rtl/cdc_tx_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_cdc_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_tx_scheduler_if.sv
// Requester, channel and status bundle of the clock-domain-A CDC transmit scheduler.
// master is the scheduler side; slave is the requester/channel side.
`timescale 1ns/1ps
interface cdc_tx_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [3:0]         sync_data;
    logic               sync_en;
    logic               ack_tgl;
    logic               clr_err;
    logic               err_timeout;

    modport master (
        input  req, req_data, ack_tgl, clr_err,
        output gnt, done, busy, sync_data, sync_en, err_timeout
    );

    modport slave (
        output req, req_data, ack_tgl, clr_err,
        input  gnt, done, busy, sync_data, sync_en, err_timeout
    );
endinterface

// File: rtl/cdc_tx_scheduler.sv
// Round-robin scheduler driving a 4-bit enable-qualified CDC channel from clk_a.
// Holds enable and data for programmed windows, optionally waiting for a toggle ack from clk_b.
`timescale 1ns/1ps
module cdc_tx_scheduler #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned EN_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter bit          USE_ACK     = 1'b1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic               clk_a,
    input  logic               arstn,
    cdc_tx_scheduler_if.master bus
);

    localparam int unsigned MAX_EH  = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_EH > TIMEOUT) ? MAX_EH : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned IDX_W   = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StHold,
        StWaitAck,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [3:0]         data_q, data_d;
    logic               en_q, en_d;
    logic               err_q, err_d;
    logic               err_set;

    logic               ack_s1_q, ack_s2_q, ack_last_q;
    logic               ack_edge;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic [N_REQ-1:0]   sel_oh;
    logic [3:0]         sel_data;
    int unsigned        cand;

    // The edge register tracks the synchronized level in every state, so toggles
    // arriving outside the ack wait are consumed and never seen later.
    assign ack_edge = ack_s2_q ^ ack_last_q;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = 32'(rr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_valid && bus.req[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_data  = bus.req_data[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = '0;
        data_d  = data_q;
        en_d    = en_q;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (sel_valid) begin
                    state_d = StAssert;
                    gnt_d   = sel_oh;
                    owner_d = sel_oh;
                    data_d  = sel_data;
                    en_d    = 1'b1;
                    rr_d    = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
                end
            end
            StAssert: begin
                if (cnt_q == EN_LAST) begin
                    state_d = StHold;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (USE_ACK) begin
                        state_d = StWaitAck;
                    end else begin
                        state_d = StDone;
                        done_d  = owner_q;
                    end
                end
            end
            StWaitAck: begin
                // A real ack on the final cycle still counts as an ack, not a timeout.
                if (ack_edge) begin
                    state_d = StDone;
                    done_d  = owner_q;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = StDone;
                    done_d  = owner_q;
                    cnt_d   = '0;
                    err_set = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d != StIdle);
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rr_q       <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_s1_q   <= 1'b0;
            ack_s2_q   <= 1'b0;
            ack_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            en_q       <= en_d;
            err_q      <= err_d;
            ack_s1_q   <= bus.ack_tgl;
            ack_s2_q   <= ack_s1_q;
            ack_last_q <= ack_s2_q;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.sync_data   = data_q;
    assign bus.sync_en     = en_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed bench for cdc_tx_scheduler: one instance without ack wait, one with.
// Cycle n below means the cycle after the n-th rising edge following request setup.
`timescale 1ns/1ps
module tb_cdc_tx_scheduler;

    logic clk_a = 1'b0;
    logic arstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_a = ~clk_a;

    cdc_tx_scheduler_if #(.N_REQ(4)) a0 ();
    cdc_tx_scheduler_if #(.N_REQ(4)) a1 ();

    cdc_tx_scheduler #(
        .N_REQ(4), .EN_CYCLES(4), .HOLD_CYCLES(4), .USE_ACK(1'b0), .TIMEOUT(64)
    ) u_dut0 (
        .clk_a(clk_a),
        .arstn(arstn),
        .bus  (a0)
    );

    cdc_tx_scheduler #(
        .N_REQ(4), .EN_CYCLES(4), .HOLD_CYCLES(4), .USE_ACK(1'b1), .TIMEOUT(64)
    ) u_dut1 (
        .clk_a(clk_a),
        .arstn(arstn),
        .bus  (a1)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_a);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] outs0();
        return {a0.gnt, a0.done, a0.busy, a0.sync_en, a0.sync_data, a0.err_timeout};
    endfunction

    function automatic logic [14:0] outs1();
        return {a1.gnt, a1.done, a1.busy, a1.sync_en, a1.sync_data, a1.err_timeout};
    endfunction

    // Bounded wait for the next grant on the no-ack instance; 0 means none arrived.
    task automatic wait_gnt0(output logic [3:0] g);
        bit seen;
        seen = 1'b0;
        g    = '0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                tick(1);
                if (a0.gnt != 4'b0000) begin
                    g    = a0.gnt;
                    seen = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [3:0] rr_exp [0:4];
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        a0.req = '0; a0.req_data = '0; a0.ack_tgl = 1'b0; a0.clr_err = 1'b0;
        a1.req = '0; a1.req_data = '0; a1.ack_tgl = 1'b0; a1.clr_err = 1'b0;

        tick(3);
        chk("reset_outs0", 32'(outs0()), 32'h0);
        chk("reset_outs1", 32'(outs1()), 32'h0);
        arstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("idle_outs0", 32'(outs0()), 32'h0);
            chk("idle_outs1", 32'(outs1()), 32'h0);
        end

        // Single transfer, no ack: req[2] with data A.
        a0.req_data = 16'h0A00;
        a0.req      = 4'b0100;
        tick(1);
        chk("single_gnt", 32'(a0.gnt), 32'h4);
        chk("single_en_c1", 32'(a0.sync_en), 32'h1);
        chk("single_data_c1", 32'(a0.sync_data), 32'hA);
        chk("single_busy_c1", 32'(a0.busy), 32'h1);
        a0.req = 4'b0000;
        tick(1);
        chk("single_gnt_pulse", 32'(a0.gnt), 32'h0);
        chk("single_en_c2", 32'(a0.sync_en), 32'h1);
        for (int c = 3; c <= 4; c++) begin
            tick(1);
            chk("single_en_hi", 32'(a0.sync_en), 32'h1);
        end
        for (int c = 5; c <= 8; c++) begin
            tick(1);
            chk("single_en_lo", 32'(a0.sync_en), 32'h0);
            chk("single_hold_data", 32'(a0.sync_data), 32'hA);
            chk("single_no_done", 32'(a0.done), 32'h0);
        end
        tick(1);
        chk("single_done", 32'(a0.done), 32'h4);
        chk("single_busy_c9", 32'(a0.busy), 32'h1);
        tick(1);
        chk("single_done_pulse", 32'(a0.done), 32'h0);
        chk("single_busy_c10", 32'(a0.busy), 32'h0);
        chk("single_data_kept", 32'(a0.sync_data), 32'hA);

        // Reset restores pointer 0 before the round-robin sequence.
        arstn = 1'b0;
        tick(2);
        arstn = 1'b1;
        tick(1);

        a0.req_data = 16'h4321;
        a0.req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt0(g);
            chk("rr_grant", 32'(g), 32'(rr_exp[k]));
        end
        a0.req = 4'b1001;
        wait_gnt0(g);
        chk("rr_1001_first", 32'(g), 32'h8);
        wait_gnt0(g);
        chk("rr_1001_second", 32'(g), 32'h1);
        a0.req = 4'b0000;
        tick(12);
        chk("rr_idle", 32'(a0.busy), 32'h0);

        // Ack path: stray toggle in ASSERT, real toggle two cycles into WAIT_ACK (cycle 9).
        a1.req_data = 16'h0005;
        a1.req      = 4'b0001;
        tick(1);
        chk("ack_gnt", 32'(a1.gnt), 32'h1);
        chk("ack_data", 32'(a1.sync_data), 32'h5);
        a1.req = 4'b0000;
        tick(1);
        a1.ack_tgl = 1'b1;
        tick(1);
        chk("ack_en_c3", 32'(a1.sync_en), 32'h1);
        tick(1);
        chk("ack_en_c4", 32'(a1.sync_en), 32'h1);
        tick(1);
        chk("ack_en_c5", 32'(a1.sync_en), 32'h0);
        tick(4);
        chk("ack_wait_busy", 32'(a1.busy), 32'h1);
        chk("ack_wait_nodone", 32'(a1.done), 32'h0);
        tick(1);
        chk("ack_nodone_c10", 32'(a1.done), 32'h0);
        tick(1);
        chk("ack_nodone_c11", 32'(a1.done), 32'h0);
        a1.ack_tgl = 1'b0;
        tick(1);
        chk("ack_nodone_c12", 32'(a1.done), 32'h0);
        tick(1);
        chk("ack_nodone_c13", 32'(a1.done), 32'h0);
        tick(1);
        chk("ack_done_c14", 32'(a1.done), 32'h1);
        chk("ack_no_err", 32'(a1.err_timeout), 32'h0);
        tick(1);
        chk("ack_idle", 32'(a1.busy), 32'h0);

        // Timeout: WAIT_ACK entered in cycle 9, forced done in cycle 73.
        a1.req_data = 16'h0003;
        a1.req      = 4'b0001;
        tick(1);
        chk("to_gnt", 32'(a1.gnt), 32'h1);
        a1.req = 4'b0000;
        tick(71);
        chk("to_nodone_c72", 32'(a1.done), 32'h0);
        chk("to_noerr_c72", 32'(a1.err_timeout), 32'h0);
        tick(1);
        chk("to_done_c73", 32'(a1.done), 32'h1);
        chk("to_err_c73", 32'(a1.err_timeout), 32'h1);
        tick(1);
        chk("to_err_sticky", 32'(a1.err_timeout), 32'h1);
        chk("to_idle", 32'(a1.busy), 32'h0);
        a1.clr_err = 1'b1;
        tick(1);
        chk("to_err_cleared", 32'(a1.err_timeout), 32'h0);
        a1.clr_err = 1'b0;

        // Second timeout with clr_err on the very cycle the timeout fires.
        a1.req = 4'b0001;
        tick(1);
        chk("to2_gnt", 32'(a1.gnt), 32'h1);
        a1.req = 4'b0000;
        tick(71);
        a1.clr_err = 1'b1;
        chk("to2_noerr_c72", 32'(a1.err_timeout), 32'h0);
        tick(1);
        a1.clr_err = 1'b0;
        chk("to2_set_wins", 32'(a1.err_timeout), 32'h1);
        chk("to2_done", 32'(a1.done), 32'h1);
        tick(1);
        chk("to2_err_kept", 32'(a1.err_timeout), 32'h1);

        // Reset during HOLD: pointer is 1 after round robin, so req[1] wins first.
        a0.req_data = 16'h00B0;
        a0.req      = 4'b0010;
        tick(1);
        chk("rst_gnt", 32'(a0.gnt), 32'h2);
        chk("rst_data", 32'(a0.sync_data), 32'hB);
        a0.req = 4'b0000;
        tick(5);
        chk("rst_in_hold", 32'({a0.busy, a0.sync_en}), 32'h2);
        arstn = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs0()), 32'h0);
        tick(2);
        arstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            chk("rst_no_done", 32'(outs0()), 32'h0);
        end
        a0.req_data = 16'h0C0D;
        a0.req      = 4'b0101;
        tick(1);
        chk("rst_regrant_idx0", 32'(a0.gnt), 32'h1);
        chk("rst_regrant_data", 32'(a0.sync_data), 32'hD);
        a0.req = 4'b0000;
        tick(12);
        chk("rst_final_idle", 32'(a0.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
